uart_rx_pkt_ctrl: RTL and testbench

//  Packet controller behind the byte-level UART receiver. Consumes its i_rx_dv/i_rx_byte/i_rx_error stream.

---
 rtl/uart_pkt_pkg.sv | 23 ++
 rtl/uart_pkt_buf.sv | 26 ++
 rtl/uart_rx_pkt_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART RX packet controller.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN_BAD = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_FRAMING = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, combinational read.
module uart_pkt_buf
    import uart_pkt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind uart_rx: sync hunt, length-prefixed payload, 8-bit additive checksum,
// valid/ready drain. Optional inter-byte timeout is built when UART_PKT_TIMEOUT_EN is defined.
//
//  state   | meaning
//  HUNT    | waiting for SYNC_BYTE, other bytes ignored
//  LEN     | next byte is payload length (1..MAX_LEN)
//  PAYLOAD | storing payload bytes into the buffer
//  CSUM    | next byte must bring the running sum to zero
//  DRAIN   | releasing buffered payload downstream
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 200000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_error,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_pkt_ok,
    output logic       o_pkt_err,
    output logic [1:0] o_err_code,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int AW = addr_width(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_rx_pkt_ctrl: MAX_LEN or TIMEOUT_CYC out of range");
    end

    state_t        state, state_n;
    logic [7:0]    len, len_n;
    logic [7:0]    csum, csum_n;
    logic [AW-1:0] wr_ptr, wr_ptr_n;
    logic [AW-1:0] rd_ptr, rd_ptr_n;
    logic          pkt_ok_n, pkt_err_n, overrun_n;
    logic [1:0]    err_code_n;
    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic [7:0]    csum_sum;
    logic [7:0]    last_idx;
    logic          tmo_hit;

    assign csum_sum = csum + i_rx_byte;
    assign last_idx = len - 8'd1;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .i_clk (i_clk),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (i_rx_byte),
        .raddr (rd_ptr_n),
        .rdata (buf_rdata)
    );

`ifdef UART_PKT_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        in_pkt;

    assign in_pkt  = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    assign tmo_hit = in_pkt && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt <= '0;
        end else if (!in_pkt || i_rx_dv || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        len_n      = len;
        csum_n     = csum;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        pkt_ok_n   = 1'b0;
        pkt_err_n  = 1'b0;
        err_code_n = o_err_code;
        overrun_n  = 1'b0;
        buf_we     = 1'b0;

        case (state)
            HUNT: begin
                // a strobe flagged with a framing error never counts as sync
                if (i_rx_dv && !i_rx_error && (i_rx_byte == SYNC_BYTE)) begin
                    state_n = LEN;
                end
            end
            LEN: begin
                if (i_rx_error) begin
                    state_n    = HUNT;
                    pkt_err_n  = 1'b1;
                    err_code_n = ERR_FRAMING;
                end else if (i_rx_dv) begin
                    if ((i_rx_byte == 8'd0) || (i_rx_byte > 8'(MAX_LEN))) begin
                        state_n    = HUNT;
                        pkt_err_n  = 1'b1;
                        err_code_n = ERR_LEN_BAD;
                    end else begin
                        len_n    = i_rx_byte;
                        csum_n   = i_rx_byte;
                        wr_ptr_n = '0;
                        state_n  = PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    state_n    = HUNT;
                    pkt_err_n  = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                end
            end
            PAYLOAD: begin
                if (i_rx_error) begin
                    state_n    = HUNT;
                    pkt_err_n  = 1'b1;
                    err_code_n = ERR_FRAMING;
                end else if (i_rx_dv) begin
                    buf_we   = 1'b1;
                    csum_n   = csum_sum;
                    wr_ptr_n = wr_ptr + 1'b1;
                    if (8'(wr_ptr) == last_idx) begin
                        state_n = CSUM;
                    end
                end else if (tmo_hit) begin
                    state_n    = HUNT;
                    pkt_err_n  = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                end
            end
            CSUM: begin
                if (i_rx_error) begin
                    state_n    = HUNT;
                    pkt_err_n  = 1'b1;
                    err_code_n = ERR_FRAMING;
                end else if (i_rx_dv) begin
                    if (csum_sum == 8'd0) begin
                        pkt_ok_n = 1'b1;
                        rd_ptr_n = '0;
                        state_n  = DRAIN;
                    end else begin
                        state_n    = HUNT;
                        pkt_err_n  = 1'b1;
                        err_code_n = ERR_CSUM;
                    end
                end else if (tmo_hit) begin
                    state_n    = HUNT;
                    pkt_err_n  = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                end
            end
            DRAIN: begin
                overrun_n = i_rx_dv;
                if (o_valid && i_ready) begin
                    if (8'(rd_ptr) == last_idx) begin
                        state_n = HUNT;
                    end else begin
                        rd_ptr_n = rd_ptr + 1'b1;
                    end
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    // Outputs are registered from next-state values so DRAIN shows valid data on entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= HUNT;
            len        <= '0;
            csum       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_last     <= 1'b0;
            o_pkt_ok   <= 1'b0;
            o_pkt_err  <= 1'b0;
            o_err_code <= '0;
            o_overrun  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_n;
            len        <= len_n;
            csum       <= csum_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            o_valid    <= (state_n == DRAIN);
            o_data     <= (state_n == DRAIN) ? buf_rdata : 8'd0;
            o_last     <= (state_n == DRAIN) && (8'(rd_ptr_n) == (len_n - 8'd1));
            o_pkt_ok   <= pkt_ok_n;
            o_pkt_err  <= pkt_err_n;
            o_err_code <= err_code_n;
            o_overrun  <= overrun_n;
            o_busy     <= (state_n != HUNT);
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl; timeout sequence runs when UART_PKT_TIMEOUT_EN is defined.
module tb_uart_rx_pkt_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx_dv = 1'b0;
    logic [7:0] i_rx_byte = 8'h00;
    logic       i_rx_error = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic       o_pkt_ok;
    logic       o_pkt_err;
    logic [1:0] o_err_code;
    logic       o_overrun;
    logic       o_busy;

    uart_rx_pkt_ctrl #(
        .MAX_LEN     (16),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (50)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_dv    (i_rx_dv),
        .i_rx_byte  (i_rx_byte),
        .i_rx_error (i_rx_error),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_pkt_ok   (o_pkt_ok),
        .o_pkt_err  (o_pkt_err),
        .o_err_code (o_err_code),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    logic [8:0] out_q [$];
    logic [7:0] exp_q [$];
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // Frame bytes are written in send order, first byte in the most significant position.
    typedef struct {
        int          n;
        logic [79:0] b;
        logic [9:0]  e;
        int          n_ok;
        int          n_err;
        int          code;
        int          n_out;
        int          pay;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    // Monitor: pulse counters, accepted transfers, and hold-while-stalled check.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (o_pkt_ok)  ok_cnt  <= ok_cnt + 1;
            if (o_pkt_err) err_cnt <= err_cnt + 1;
            if (o_overrun) ovr_cnt <= ovr_cnt + 1;
            if (o_valid && i_ready) out_q.push_back({o_last, o_data});
            if (prev_v && !prev_r) begin
                tests <= tests + 1;
                if (!o_valid || (o_data != prev_d)) begin
                    fails <= fails + 1;
                    $display("FAIL stall_hold actual valid=%0b data=%02h required valid=1 data=%02h",
                             o_valid, o_data, prev_d);
                end
            end
            prev_v <= o_valid;
            prev_r <= i_ready;
            prev_d <= o_data;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        i_rx_dv    = 1'b1;
        i_rx_byte  = b;
        i_rx_error = e;
        tick();
        i_rx_dv    = 1'b0;
        i_rx_error = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 80 && o_busy; k++) tick();
        chk("idle_bound", int'(o_busy), 0);
    endtask

    task automatic check_out(input string tag);
        int n;
        logic [8:0] got;
        n = exp_q.size();
        chk({tag, "_nout"}, out_q.size(), n);
        for (int i = 0; i < n && out_q.size() > 0; i++) begin
            got = out_q.pop_front();
            chk({tag, "_data"}, int'(got[7:0]), int'(exp_q[i]));
            chk({tag, "_last"}, int'(got[8]), (i == n - 1) ? 1 : 0);
        end
        out_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] vbyte(input vec_t x, input int i);
        return x.b[8*(x.n-1-i) +: 8];
    endfunction

    initial begin
        int ok0, er0, ov0;
        logic [7:0] sum;
        logic [7:0] d;

        //               n  bytes                       err mask        ok err code nout pay
        vec[0] = '{6, 80'hA5_03_11_22_33_97,       10'b00_0000_0000, 1, 0, 0, 3, 2};
        vec[1] = '{6, 80'hA5_03_11_22_33_C0,       10'b00_0000_0000, 0, 1, 1, 0, 2};
        vec[2] = '{2, 80'hA5_00,                   10'b00_0000_0000, 0, 1, 0, 0, 2};
        vec[3] = '{2, 80'hA5_11,                   10'b00_0000_0000, 0, 1, 0, 0, 2};
        vec[4] = '{4, 80'hA5_01_42_BD,             10'b00_0000_0000, 1, 0, 0, 1, 2};
        vec[5] = '{5, 80'h5A_A5_03_11_22,          10'b00_0001_0000, 0, 1, 2, 0, 3};
        vec[6] = '{5, 80'hA5_02_A5_A5_B4,          10'b00_0000_0000, 1, 0, 2, 2, 2};
        vec[7] = '{5, 80'h5A_A5_01_42_BD,          10'b00_0000_0001, 1, 0, 2, 1, 3};

        i_rst = 1'b1;
        repeat (3) tick();
        chk("rst_outputs", int'({o_valid, o_last, o_pkt_ok, o_pkt_err, o_overrun, o_busy, o_err_code, o_data}), 0);
        i_rst = 1'b0;
        tick();
        chk("rst_busy", int'(o_busy), 0);

        i_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            ok0 = ok_cnt;
            er0 = err_cnt;
            for (int i = 0; i < vec[v].n; i++) send_byte(vbyte(vec[v], i), vec[v].e[i]);
            wait_idle();
            for (int j = 0; j < vec[v].n_out; j++) exp_q.push_back(vbyte(vec[v], vec[v].pay + j));
            chk($sformatf("v%0d_ok", v), ok_cnt - ok0, vec[v].n_ok);
            chk($sformatf("v%0d_err", v), err_cnt - er0, vec[v].n_err);
            chk($sformatf("v%0d_code", v), int'(o_err_code), vec[v].code);
            check_out($sformatf("v%0d", v));
        end

        // Stalled drain with ready toggling and a stray byte arriving mid-drain.
        ok0 = ok_cnt;
        ov0 = ovr_cnt;
        i_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h97, 1'b0);
        chk("stall_valid_held", int'(o_valid), 1);
        for (int k = 0; k < 40 && o_busy; k++) begin
            i_ready   = (k % 2 == 0);
            i_rx_dv   = (k == 1);
            i_rx_byte = 8'h77;
            tick();
        end
        i_rx_dv = 1'b0;
        i_ready = 1'b1;
        chk("stall_idle", int'(o_busy), 0);
        chk("stall_ok", ok_cnt - ok0, 1);
        chk("stall_overrun", ovr_cnt - ov0, 1);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        check_out("stall");

        // Maximum-length packet.
        ok0 = ok_cnt;
        sum = 8'h10;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 17 + 3);
            sum = sum + d;
            exp_q.push_back(d);
            send_byte(d, 1'b0);
        end
        send_byte(8'h00 - sum, 1'b0);
        wait_idle();
        chk("max_ok", ok_cnt - ok0, 1);
        check_out("max");

        // Asynchronous reset while draining, then recovery.
        i_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h97, 1'b0);
        chk("mid_rst_pre_valid", int'(o_valid), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_outputs", int'({o_valid, o_last, o_pkt_ok, o_pkt_err, o_overrun, o_busy, o_data}), 0);
        chk("mid_rst_code", int'(o_err_code), 0);
        tick();
        i_rst = 1'b0;
        tick();
        out_q.delete();
        i_ready = 1'b1;
        ok0 = ok_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'hBD, 1'b0);
        wait_idle();
        chk("post_rst_ok", ok_cnt - ok0, 1);
        exp_q.push_back(8'h42);
        check_out("post_rst");

`ifdef UART_PKT_TIMEOUT_EN
        er0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        for (int k = 0; k < 70 && err_cnt == er0; k++) tick();
        chk("tmo_err", err_cnt - er0, 1);
        chk("tmo_code", int'(o_err_code), 3);
        chk("tmo_busy", int'(o_busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
